// File: rtl/cntr_sw_reg_blk.sv
// Leaf register block: hardware event counters plus host read/write control registers,
// reached through a req/ack handshake that gives one ack per request.
//
// state    | meaning
// IDLE     | waiting for reg_req; the access executes on the edge that sees it
// ACK      | reg_ack high for this single cycle, reg_rd_data valid
// WAIT_LOW | waiting for upstream to drop reg_req before the next access
module cntr_sw_reg_blk #(
   parameter int REG_ADDR_BITS     = 8,
   parameter int NUM_COUNTERS      = 8,
   parameter int NUM_SOFTWARE_REGS = 4,
   parameter int COUNTER_WIDTH     = 32,
   parameter int COUNTER_INC_WIDTH = 1,
   parameter int RESET_ON_READ     = 0,
   parameter int SATURATE          = 0
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           reg_req,
   input  logic                                           reg_rd_wr_L,
   input  logic [REG_ADDR_BITS-1:0]                       reg_addr,
   input  logic [31:0]                                    reg_wr_data,
   output logic                                           reg_ack,
   output logic [31:0]                                    reg_rd_data,
   input  logic [NUM_COUNTERS*COUNTER_INC_WIDTH-1:0]      counter_updates,
   output logic [NUM_SOFTWARE_REGS*32-1:0]                software_regs
);

   localparam int unsigned NC = NUM_COUNTERS;
   localparam int unsigned NS = NUM_SOFTWARE_REGS;
   localparam int SUM_W = ((COUNTER_WIDTH > COUNTER_INC_WIDTH) ? COUNTER_WIDTH : COUNTER_INC_WIDTH) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-COUNTER_WIDTH){1'b0}}, {COUNTER_WIDTH{1'b1}}};

   typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

   state_t                   state_q;
   logic                     ack_q;
   logic [31:0]              rd_data_q;
   logic [COUNTER_WIDTH-1:0] cnt_q [NUM_COUNTERS];
   logic [COUNTER_WIDTH-1:0] cnt_d [NUM_COUNTERS];
   logic [31:0]              sw_q  [NUM_SOFTWARE_REGS];
   logic [31:0]              sw_d  [NUM_SOFTWARE_REGS];
   logic [SUM_W-1:0]         base_w [NUM_COUNTERS];
   logic [SUM_W-1:0]         sum_w  [NUM_COUNTERS];
   logic [31:0]              addr_ext;
   logic [31:0]              rd_mux;
   logic                     access, do_rd, do_wr;

   assign access   = (state_q == IDLE) && reg_req;
   assign do_rd    = access && reg_rd_wr_L;
   assign do_wr    = access && !reg_rd_wr_L;
   assign addr_ext = 32'(reg_addr);

   always_comb begin
      rd_mux = 32'hDEADBEEF;
      for (int unsigned i = 0; i < NC; i++)
         if (addr_ext == i) rd_mux = 32'(cnt_q[i]);
      for (int unsigned j = 0; j < NS; j++)
         if (addr_ext == NC + j) rd_mux = sw_q[j];
   end

   // A clear-on-read restarts from zero but still absorbs this cycle's increment.
   always_comb begin
      for (int unsigned i = 0; i < NC; i++) begin
         base_w[i] = (do_rd && (RESET_ON_READ != 0) && (addr_ext == i)) ? '0 : SUM_W'(cnt_q[i]);
         sum_w[i]  = base_w[i] + SUM_W'(counter_updates[i*COUNTER_INC_WIDTH +: COUNTER_INC_WIDTH]);
         if ((SATURATE != 0) && (sum_w[i] > CNT_MAX)) cnt_d[i] = CNT_MAX[COUNTER_WIDTH-1:0];
         else                                         cnt_d[i] = sum_w[i][COUNTER_WIDTH-1:0];
         if (do_wr && (addr_ext == i)) cnt_d[i] = reg_wr_data[COUNTER_WIDTH-1:0];
      end
      for (int unsigned j = 0; j < NS; j++) begin
         sw_d[j] = sw_q[j];
         if (do_wr && (addr_ext == NC + j)) sw_d[j] = reg_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_COUNTERS; i++)      cnt_q[i] <= '0;
         for (int j = 0; j < NUM_SOFTWARE_REGS; j++) sw_q[j]  <= '0;
      end else begin
         for (int i = 0; i < NUM_COUNTERS; i++)      cnt_q[i] <= cnt_d[i];
         for (int j = 0; j < NUM_SOFTWARE_REGS; j++) sw_q[j]  <= sw_d[j];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (reg_req) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
                  if (reg_rd_wr_L) rd_data_q <= rd_mux;
               end
            end
            ACK:      state_q <= WAIT_LOW;
            WAIT_LOW: if (!reg_req) state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

   assign reg_ack     = ack_q;
   assign reg_rd_data = rd_data_q;

   for (genvar j = 0; j < NUM_SOFTWARE_REGS; j++) begin : g_sw_out
      assign software_regs[j*32 +: 32] = sw_q[j];
   end

endmodule
